// File: rtl/pc_pkg.sv
// Shared constants, types and select encoding for the fetch-stage program counter.
`timescale 1ns/1ps
package pc_pkg;

  localparam int unsigned ADDR_W = 16;

  typedef logic [ADDR_W-1:0] addr_t;

  localparam addr_t       RESET_ADDR = 16'h0000;
  localparam int unsigned INCR       = 1;

  typedef enum logic {
    NEXT_INC    = 1'b0,
    NEXT_BRANCH = 1'b1
  } next_sel_e;

endpackage

// File: rtl/program_counter.sv
// Fetch-stage instruction-address register: increments by INCR or loads a branch target.
// Optional PROGRAM_COUNTER_STALL_EN adds a stall input that holds the address.
`timescale 1ns/1ps
module program_counter #(
  parameter int unsigned          ADDR_W     = pc_pkg::ADDR_W,
  parameter logic [ADDR_W-1:0]    RESET_ADDR = pc_pkg::RESET_ADDR,
  parameter int unsigned          INCR       = pc_pkg::INCR
) (
  input  logic              clk,
  input  logic              reset,
`ifdef PROGRAM_COUNTER_STALL_EN
  input  logic              stall,
`endif
  input  logic [ADDR_W-1:0] branch_addr,
  input  logic              sel_next,
  output logic [ADDR_W-1:0] addr_out
);

  import pc_pkg::*;

  localparam logic [ADDR_W-1:0] L_INCR = ADDR_W'(INCR);

  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] w_next;
  next_sel_e         w_sel;

  assign w_sel = next_sel_e'(sel_next);

  // NOTE: w_next is assigned a default before any branching, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_next = r_addr + L_INCR;
    case (w_sel)
      NEXT_BRANCH: w_next = branch_addr;
      default:     w_next = r_addr + L_INCR;
    endcase
`ifdef PROGRAM_COUNTER_STALL_EN
    if (stall) w_next = r_addr;
`endif
  end

  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_addr <= RESET_ADDR;
    else       r_addr <= w_next;
  end

  assign addr_out = r_addr;

endmodule

// File: tb/tb_program_counter.sv
// Randomized self-checking bench for program_counter against an arithmetic reference model.
// Exercises the stall port when PROGRAM_COUNTER_STALL_EN is defined.
`timescale 1ns/1ps
module tb_program_counter;
  import pc_pkg::*;

  logic  clk = 1'b0;
  logic  reset;
  logic  sel_next;
  logic  stall;
  addr_t branch_addr;
  addr_t addr_out;

  int n_checks = 0;
  int n_errors = 0;
  int exp_pc;

  program_counter dut (
    .clk        (clk),
    .reset      (reset),
`ifdef PROGRAM_COUNTER_STALL_EN
    .stall      (stall),
`endif
    .branch_addr(branch_addr),
    .sel_next   (sel_next),
    .addr_out   (addr_out)
  );

  always #1 clk = ~clk;

  task automatic check(input string tag, input addr_t got, input addr_t exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
    end
  endtask

  // Called right after a falling edge: drive inputs, let one rising edge pass, check at the next falling edge.
  task automatic step(input logic sel, input addr_t tgt, input logic stl, input string tag);
    bit stall_eff;
    sel_next    = sel;
    branch_addr = tgt;
    stall       = stl;
`ifdef PROGRAM_COUNTER_STALL_EN
    stall_eff = stl;
`else
    stall_eff = 1'b0;
`endif
    @(posedge clk);
    if (!stall_eff) exp_pc = sel ? int'(tgt) : (exp_pc + 1) % 65536;
    @(negedge clk);
    check(tag, addr_out, addr_t'(exp_pc));
  endtask

  // Assert reset between edges, verify it takes effect without a clock, hold, then release.
  task automatic async_reset(input int hold_cycles, input string tag);
    #0.3 reset = 1'b1;
    #0.2 check({tag, "_async"}, addr_out, 16'h0000);
    for (int i = 0; i < hold_cycles; i++) begin
      @(negedge clk);
      check({tag, "_held"}, addr_out, 16'h0000);
    end
    reset  = 1'b0;
    exp_pc = 0;
  endtask

  initial begin
    reset       = 1'b1;
    sel_next    = 1'b0;
    stall       = 1'b0;
    branch_addr = '0;

    #0.5 check("reset_immediate", addr_out, 16'h0000);
    repeat (4) begin
      @(negedge clk);
      check("reset_hold", addr_out, 16'h0000);
    end
    @(negedge clk);
    reset  = 1'b0;
    exp_pc = 0;

    for (int i = 0; i < 50; i++) step(1'b0, addr_t'($urandom), 1'b0, "inc");
    check("inc_50", addr_out, 16'h0032);

    step(1'b1, 16'h1388, 1'b0, "branch");
    check("branch_1388", addr_out, 16'h1388);
    step(1'b0, 16'h0000, 1'b0, "post_branch");
    check("post_branch_1389", addr_out, 16'h1389);
    step(1'b0, 16'hBEEF, 1'b0, "post_branch");
    check("post_branch_138a", addr_out, 16'h138A);

    for (int i = 0; i < 5; i++) step(1'b1, 16'h1388, 1'b0, "held_branch");
    check("held_1388", addr_out, 16'h1388);
    step(1'b1, 16'h00AA, 1'b0, "new_target");
    check("target_00aa", addr_out, 16'h00AA);

    step(1'b1, 16'hFFFE, 1'b0, "wrap_load");
    step(1'b0, 16'h0000, 1'b0, "wrap");
    check("wrap_ffff", addr_out, 16'hFFFF);
    step(1'b0, 16'h0000, 1'b0, "wrap");
    check("wrap_0000", addr_out, 16'h0000);
    step(1'b0, 16'h0000, 1'b0, "wrap");
    check("wrap_0001", addr_out, 16'h0001);

    step(1'b1, 16'h13A0, 1'b0, "pre_reset");
    sel_next    = 1'b1;
    branch_addr = 16'h4444;
    async_reset(3, "midrun");
    step(1'b0, 16'h0000, 1'b0, "after_reset");
    check("after_reset_1", addr_out, 16'h0001);
    step(1'b0, 16'h0000, 1'b0, "after_reset");
    check("after_reset_2", addr_out, 16'h0002);

`ifdef PROGRAM_COUNTER_STALL_EN
    sel_next = 1'b0;
    async_reset(1, "stall_prep");
    for (int i = 0; i < 16; i++) step(1'b0, 16'h0000, 1'b0, "stall_prep");
    check("stall_at_0010", addr_out, 16'h0010);
    for (int i = 0; i < 3; i++) step(1'b0, 16'h0000, 1'b1, "stall");
    check("stall_hold", addr_out, 16'h0010);
    step(1'b1, 16'h1234, 1'b1, "stall_over_branch");
    check("stall_prio", addr_out, 16'h0010);
    step(1'b0, 16'h0000, 1'b0, "stall_release");
    check("stall_resume", addr_out, 16'h0011);
    stall = 1'b1;
    async_reset(1, "stall_reset");
`endif

    for (int i = 0; i < 600; i++) begin
      int unsigned r;
      r = $urandom_range(0, 99);
      if (r < 2) begin
        async_reset($urandom_range(0, 2), "rand_reset");
      end else begin
        step($urandom_range(0, 99) < 30, addr_t'($urandom), $urandom_range(0, 99) < 15, "random");
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
